sym_fir_pair_sequencer: RTL and testbench

Parametrised successor to the fixed 33-tap symmetric delay chain. It holds an NTAP-deep signed sample delay line and pre-adds each symmetric tap pair. Instead of presenting all pair sums in parallel, it streams the enabled pair sums one per clock, each tagged with its pair index, to a single downstream MAC. Pairs whose coefficient is zero are skipped via a compile-time mask, and sample-rate violations are flagged.

---
 rtl/sym_fir_pair_sequencer.sv | 144 ++++++++++++++
 tb/tb_sym_fir_pair_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/sym_fir_pair_sequencer.sv
// Symmetric FIR delay line with tap-pair pre-adders.
// Enabled pair sums are streamed one per clock to a shared MAC.
//
// state  | meaning
// S_IDLE | no scan pending, beats idle
// S_SCAN | emitting enabled pair sums, one per cycle
module sym_fir_pair_sequencer #(
  parameter int NTAP = 33,
  parameter int DW   = 3,
  parameter int SW   = 16,
  parameter logic [((NTAP+1)/2)-1:0] PAIR_MASK = 17'h1_DB6D
) (
  input  logic                                iClk_12M,
  input  logic                                iRst,
  input  logic                                iEnSample,
  input  logic                                iEnDelay,
  input  logic [DW-1:0]                       iFirIn,
  input  logic                                iFlush,
  output logic [SW-1:0]                       oPairSum,
  output logic [$clog2((NTAP+1)/2)-1:0]       oPairIdx,
  output logic                                oPairVld,
  output logic                                oPairLast,
  output logic                                oBusy,
  output logic                                oOverrun
);
  localparam int NPAIR = (NTAP + 1) / 2;
  localparam int IW    = $clog2(NPAIR);

  if (NTAP < 3 || (NTAP % 2) == 0) begin : g_bad_ntap
    $error("NTAP must be odd and at least 3");
  end
  if (SW < DW + 1) begin : g_bad_sw
    $error("SW must be at least DW+1");
  end
  if (PAIR_MASK == '0) begin : g_bad_mask
    $error("PAIR_MASK must enable at least one pair");
  end

  function automatic int lo_bit();
    int r = 0;
    for (int i = NPAIR - 1; i >= 0; i--) if (PAIR_MASK[i]) r = i;
    return r;
  endfunction

  function automatic int hi_bit();
    int r = 0;
    for (int i = 0; i < NPAIR; i++) if (PAIR_MASK[i]) r = i;
    return r;
  endfunction

  function automatic logic [SW-1:0] ext(input logic [DW-1:0] v);
    return {{(SW-DW){v[DW-1]}}, v};
  endfunction

  localparam logic [IW-1:0] FIRST_PAIR = IW'(lo_bit());
  localparam logic [IW-1:0] LAST_PAIR  = IW'(hi_bit());

  typedef enum logic {S_IDLE, S_SCAN} state_t;

  state_t          state, state_nxt;
  logic [DW-1:0]   taps [NTAP];
  logic [SW-1:0]   pair_sum [NPAIR];
  logic [SW-1:0]   cur_sum, sum_nxt;
  logic [IW-1:0]   ptr, ptr_nxt, next_ptr, idx_nxt;
  logic            vld_nxt, last_nxt, ovr_nxt;
  logic            shift_req;

  assign shift_req = iEnDelay && iEnSample;
  assign oBusy     = (state == S_SCAN);

  always_comb begin
    for (int p = 0; p < NPAIR - 1; p++)
      pair_sum[p] = ext(taps[p]) + ext(taps[NTAP-1-p]);
    pair_sum[NPAIR-1] = ext(taps[NPAIR-1]);
  end

  // Mux the pair under the pointer and find the next enabled pair above it.
  always_comb begin
    cur_sum  = '0;
    next_ptr = ptr;
    for (int p = 0; p < NPAIR; p++)
      if (IW'(p) == ptr) cur_sum = pair_sum[p];
    for (int i = NPAIR - 1; i >= 0; i--)
      if (PAIR_MASK[i] && (IW'(i) > ptr)) next_ptr = IW'(i);
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    sum_nxt   = oPairSum;
    idx_nxt   = oPairIdx;
    vld_nxt   = 1'b0;
    last_nxt  = 1'b0;
    ovr_nxt   = oOverrun;
    if (iFlush) begin
      state_nxt = S_IDLE;
      ovr_nxt   = 1'b0;
    end else if (shift_req) begin
      // A new sample restarts the scan; any unfinished beats are dropped.
      if (state == S_SCAN) ovr_nxt = 1'b1;
      state_nxt = S_SCAN;
      ptr_nxt   = FIRST_PAIR;
    end else if (state == S_SCAN) begin
      vld_nxt  = 1'b1;
      idx_nxt  = ptr;
      sum_nxt  = cur_sum;
      last_nxt = (ptr == LAST_PAIR);
      ptr_nxt  = next_ptr;
      if (ptr == LAST_PAIR) state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge iClk_12M or posedge iRst) begin
    if (iRst) begin
      state     <= S_IDLE;
      ptr       <= '0;
      oPairSum  <= '0;
      oPairIdx  <= '0;
      oPairVld  <= 1'b0;
      oPairLast <= 1'b0;
      oOverrun  <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      oPairSum  <= sum_nxt;
      oPairIdx  <= idx_nxt;
      oPairVld  <= vld_nxt;
      oPairLast <= last_nxt;
      oOverrun  <= ovr_nxt;
    end
  end

  always_ff @(posedge iClk_12M or posedge iRst) begin
    if (iRst) begin
      for (int k = 0; k < NTAP; k++) taps[k] <= '0;
    end else if (iFlush) begin
      for (int k = 0; k < NTAP; k++) taps[k] <= '0;
    end else if (shift_req) begin
      taps[0] <= iFirIn;
      for (int k = 1; k < NTAP; k++) taps[k] <= taps[k-1];
    end
  end

endmodule

// File: tb/tb_sym_fir_pair_sequencer.sv
// Directed bench for sym_fir_pair_sequencer: default 33-tap build plus a 5-tap build.
module tb_sym_fir_pair_sequencer;
  logic        clk, rst;
  logic        en_sample, en_delay, flush;
  logic [2:0]  fir_in;
  logic [15:0] pair_sum;
  logic [4:0]  pair_idx;
  logic        pair_vld, pair_last, busy, overrun;

  logic        a_sample, a_delay, a_flush;
  logic [7:0]  a_in;
  logic [9:0]  a_sum;
  logic [1:0]  a_idx;
  logic        a_vld, a_last, a_busy, a_overrun;

  int checks = 0;
  int failures = 0;
  int idx_tbl [12] = '{0, 2, 3, 5, 6, 8, 9, 11, 12, 14, 15, 16};

  sym_fir_pair_sequencer dut (
    .iClk_12M(clk), .iRst(rst), .iEnSample(en_sample), .iEnDelay(en_delay),
    .iFirIn(fir_in), .iFlush(flush), .oPairSum(pair_sum), .oPairIdx(pair_idx),
    .oPairVld(pair_vld), .oPairLast(pair_last), .oBusy(busy), .oOverrun(overrun)
  );

  sym_fir_pair_sequencer #(.NTAP(5), .DW(8), .SW(10), .PAIR_MASK(3'b111)) dut_alt (
    .iClk_12M(clk), .iRst(rst), .iEnSample(a_sample), .iEnDelay(a_delay),
    .iFirIn(a_in), .iFlush(a_flush), .oPairSum(a_sum), .oPairIdx(a_idx),
    .oPairVld(a_vld), .oPairLast(a_last), .oBusy(a_busy), .oOverrun(a_overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [2:0] v, input logic en);
    en_sample = 1'b1;
    en_delay  = en;
    fir_in    = v;
    tick();
    en_sample = 1'b0;
    en_delay  = 1'b1;
  endtask

  // Full 12-beat scan: idx0 gets s0, other outer pairs s_mid, centre s_ctr.
  task automatic expect_scan(input string tag, input logic [15:0] s0, input logic [15:0] s_mid,
                             input logic [15:0] s_ctr, input logic ovr);
    logic [15:0] s;
    for (int k = 0; k < 12; k++) begin
      tick();
      s = (k == 0) ? s0 : ((k == 11) ? s_ctr : s_mid);
      chk({tag, "_vld"},  32'(pair_vld),  32'd1);
      chk({tag, "_idx"},  32'(pair_idx),  32'(idx_tbl[k]));
      chk({tag, "_sum"},  32'(pair_sum),  32'(s));
      chk({tag, "_last"}, 32'(pair_last), (k == 11) ? 32'd1 : 32'd0);
      chk({tag, "_busy"}, 32'(busy),      (k < 11) ? 32'd1 : 32'd0);
      chk({tag, "_ovr"},  32'(overrun),   32'(ovr));
    end
    tick();
    chk({tag, "_end_vld"},  32'(pair_vld),  32'd0);
    chk({tag, "_end_last"}, 32'(pair_last), 32'd0);
    chk({tag, "_end_busy"}, 32'(busy),      32'd0);
  endtask

  initial begin
    rst = 1'b1; en_sample = 1'b0; en_delay = 1'b1; flush = 1'b0; fir_in = '0;
    a_sample = 1'b0; a_delay = 1'b1; a_flush = 1'b0; a_in = '0;
    repeat (2) tick();
    chk("rst_vld",  32'(pair_vld),  32'd0);
    chk("rst_sum",  32'(pair_sum),  32'd0);
    chk("rst_idx",  32'(pair_idx),  32'd0);
    chk("rst_last", 32'(pair_last), 32'd0);
    chk("rst_busy", 32'(busy),      32'd0);
    chk("rst_ovr",  32'(overrun),   32'd0);
    chk("rst_alt_vld", 32'(a_vld),  32'd0);
    rst = 1'b0;
    repeat (2) tick();

    // Impulse
    strobe(3'd1, 1'b1);
    chk("imp_busy0", 32'(busy), 32'd1);
    chk("imp_vld0",  32'(pair_vld), 32'd0);
    expect_scan("imp1", 16'd1, 16'd0, 16'd0, 1'b0);
    repeat (6) tick();
    strobe(3'd0, 1'b1);
    expect_scan("imp2", 16'd0, 16'd0, 16'd0, 1'b0);
    repeat (6) tick();

    // Constant +3
    for (int i = 0; i < 32; i++) begin
      strobe(3'd3, 1'b1);
      repeat (19) tick();
    end
    strobe(3'd3, 1'b1);
    expect_scan("pos", 16'h0006, 16'h0006, 16'h0003, 1'b0);
    repeat (6) tick();

    // Constant -4
    for (int i = 0; i < 32; i++) begin
      strobe(3'b100, 1'b1);
      repeat (19) tick();
    end
    strobe(3'b100, 1'b1);
    expect_scan("neg", 16'hFFF8, 16'hFFF8, 16'hFFFC, 1'b0);
    repeat (6) tick();

    // Overrun: second strobe 5 cycles after the first
    strobe(3'd3, 1'b1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("ovr_a_vld",  32'(pair_vld),  32'd1);
      chk("ovr_a_idx",  32'(pair_idx),  32'(idx_tbl[k]));
      chk("ovr_a_sum",  32'(pair_sum),  (k == 0) ? 32'h0000FFFF : 32'h0000FFF8);
      chk("ovr_a_last", 32'(pair_last), 32'd0);
      chk("ovr_a_ovr",  32'(overrun),   32'd0);
    end
    strobe(3'd3, 1'b1);
    chk("ovr_rise",  32'(overrun),  32'd1);
    chk("ovr_vld0",  32'(pair_vld), 32'd0);
    chk("ovr_busy",  32'(busy),     32'd1);
    expect_scan("ovr_b", 16'hFFFF, 16'hFFF8, 16'hFFFC, 1'b1);
    repeat (3) tick();
    chk("ovr_sticky", 32'(overrun), 32'd1);

    // Flush
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_ovr",  32'(overrun),  32'd0);
    chk("flush_busy", 32'(busy),     32'd0);
    chk("flush_vld",  32'(pair_vld), 32'd0);
    strobe(3'd0, 1'b1);
    expect_scan("flush_scan", 16'd0, 16'd0, 16'd0, 1'b0);
    repeat (6) tick();

    // Gating: iEnDelay low must neither shift nor scan
    strobe(3'd3, 1'b1);
    expect_scan("gate_pre", 16'd3, 16'd0, 16'd0, 1'b0);
    repeat (3) tick();
    strobe(3'd2, 1'b0);
    chk("gate_busy", 32'(busy), 32'd0);
    repeat (2) tick();
    chk("gate_busy2", 32'(busy),     32'd0);
    chk("gate_vld",   32'(pair_vld), 32'd0);
    strobe(3'd1, 1'b1);
    expect_scan("gate_post", 16'd1, 16'd0, 16'd0, 1'b0);
    repeat (6) tick();

    // Mid-scan asynchronous reset
    strobe(3'd3, 1'b1);
    tick();
    chk("mrst_pre_vld", 32'(pair_vld), 32'd1);
    chk("mrst_pre_sum", 32'(pair_sum), 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("mrst_vld",  32'(pair_vld), 32'd0);
    chk("mrst_sum",  32'(pair_sum), 32'd0);
    chk("mrst_busy", 32'(busy),     32'd0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();

    // Alternate build: 5 taps, constant 127
    for (int i = 0; i < 5; i++) begin
      a_sample = 1'b1;
      a_in = 8'd127;
      tick();
      a_sample = 1'b0;
      if (i < 4) repeat (5) tick();
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("alt_vld",  32'(a_vld),  32'd1);
      chk("alt_idx",  32'(a_idx),  32'(k));
      chk("alt_sum",  32'(a_sum),  (k == 2) ? 32'd127 : 32'd254);
      chk("alt_last", 32'(a_last), (k == 2) ? 32'd1 : 32'd0);
    end
    tick();
    chk("alt_end_vld", 32'(a_vld),     32'd0);
    chk("alt_ovr",     32'(a_overrun), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
